// File: rtl/ma_lsu.sv
// Load/store stage for RV32I: valid/ready request, word-organised RAM with byte-lane
// steering, load extension, fault detection and configurable wait states.
module ma_lsu #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [IdxW+1:0] addr_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [MEM_DEPTH];

  logic            req_err;
  logic [IdxW-1:0] idx;
  logic [1:0]      off;
  logic [31:0]     rd_word;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [31:0]     load_data;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic            last_wait;

  assign req_ready = (state_q == StIdle) && !rst;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    // MEM_DEPTH is a power of two, so any set bit above the index field is out of range.
    if (|req_addr[ADDR_WIDTH-1:IdxW+2]) req_err = 1'b1;
  end

  assign idx       = addr_q[IdxW+1:2];
  assign off       = addr_q[1:0];
  assign rd_word   = mem[idx];
  assign lb        = rd_word[{off, 3'b000} +: 8];
  assign lh        = rd_word[{off[1], 4'b0000} +: 16];
  assign last_wait = (state_q == StWait) && (cnt_q == '0);

  always_comb begin
    load_data = rd_word;
    case (funct3_q)
      3'b000:  load_data = {{24{lb[7]}}, lb};
      3'b001:  load_data = {{16{lh[15]}}, lh};
      3'b100:  load_data = {24'b0, lb};
      3'b101:  load_data = {16'b0, lh};
      default: ;
    endcase
  end

  always_comb begin
    be = 4'hf;
    wd = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Commit happens only on the last wait edge, so a reset before then drops the store.
  always_ff @(posedge clk) begin
    if (!rst && last_wait && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[IdxW+1:0];
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              cnt_q   <= CntW'(MEM_LATENCY - 1);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'h0 : load_data;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_lsu.sv
// Self-checking bench for ma_lsu: directed cases plus random traffic against a
// byte-arithmetic memory model.
module tb_ma_lsu;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem_m [DEPTH];

  ma_lsu #(
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(bit we, int unsigned f3, int unsigned addr);
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if ((f3 == 1 || f3 == 5) && addr % 2 != 0) return 1'b1;
    if (f3 == 2 && addr % 4 != 0) return 1'b1;
    return (addr / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] ref_load(int unsigned f3, int unsigned addr);
    int unsigned w = mem_m[addr / 4];
    int unsigned v = w;
    if (f3 == 0 || f3 == 4) begin
      v = (w >> (8 * (addr % 4))) % 256;
      if (f3 == 0 && v >= 128) v += 32'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w >> (8 * (addr % 4))) % 65536;
      if (f3 == 1 && v >= 32768) v += 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic ref_store(int unsigned f3, int unsigned addr, int unsigned wdata);
    int unsigned n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    int unsigned w = mem_m[addr / 4];
    for (int i = 0; i < n; i++) begin
      int unsigned lane = addr % 4 + i;
      w = (w & ~(32'hFF << (8 * lane))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * lane));
    end
    mem_m[addr / 4] = w;
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    bit          exp_err = ref_err(we, f3, addr);
    logic [31:0] exp_rd = (we || exp_err) ? 32'h0 : ref_load(f3, addr);
    int          lat;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      check("ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("latency", 32'(lat), exp_err ? 32'd1 : 32'(LAT + 1));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("ready_resp", 32'(req_ready), 32'd0);
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    check("pulse_end", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rdata_clr", resp_rdata, 32'd0);
    if (we && !exp_err) ref_store(f3, addr, wdata);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          hs, first, second, pulses;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", {resp_rdata[30:0], resp_valid} | 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store/load
    do_req(1, 3'b010, 32'h4, 32'hDEAD_BEEF, rd, er);
    do_req(0, 3'b010, 32'h4, 32'h0, rd, er);
    check("lw_const", rd, 32'hDEAD_BEEF);

    // Byte lane store and sign/zero extension
    do_req(1, 3'b000, 32'h5, 32'h0000_0080, rd, er);
    do_req(0, 3'b000, 32'h5, 32'h0, rd, er);
    check("lb_const", rd, 32'hFFFF_FF80);
    do_req(0, 3'b100, 32'h5, 32'h0, rd, er);
    check("lbu_const", rd, 32'h0000_0080);
    do_req(0, 3'b010, 32'h4, 32'h0, rd, er);
    check("lw_merge", rd, 32'hDEAD_80EF);

    // Faults
    do_req(0, 3'b001, 32'h3, 32'h0, rd, er);
    check("lh_mis_err", 32'(er), 32'd1);
    do_req(1, 3'b010, 32'h6, 32'h1111_1111, rd, er);
    check("sw_mis_err", 32'(er), 32'd1);
    do_req(0, 3'b010, 32'h4, 32'h0, rd, er);
    check("lw_unchanged", rd, 32'hDEAD_80EF);
    do_req(0, 3'b011, 32'h0, 32'h0, rd, er);
    check("f3_011_err", 32'(er), 32'd1);
    do_req(1, 3'b100, 32'h0, 32'h0, rd, er);
    check("sbu_err", 32'(er), 32'd1);

    // Range boundary
    do_req(1, 3'b010, (DEPTH - 1) * 4, 32'hA5A5_5A5A, rd, er);
    do_req(0, 3'b010, DEPTH * 4, 32'h0, rd, er);
    check("oob_err", 32'(er), 32'd1);
    do_req(0, 3'b010, (DEPTH - 1) * 4, 32'h0, rd, er);
    check("last_word", rd, 32'hA5A5_5A5A);

    // Working set for random traffic
    for (int w = 0; w < 16; w++) do_req(1, 3'b010, w * 4, $urandom, rd, er);

    // Held req_valid: accepted only in IDLE, one response pulse per request
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    hs = 0; first = -1; second = -1; pulses = 0;
    for (int c = 0; c < 2 * (LAT + 2); c++) begin
      if (req_ready) begin
        hs++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("held_hs", 32'(hs), 32'd2);
    check("held_gap", 32'(second - first), 32'(LAT + 2));
    check("held_pulses", 32'(pulses), 32'd2);
    repeat (2) @(negedge clk);

    // Reset during WAIT drops an uncommitted store
    do_req(1, 3'b010, 32'h8, 32'hCAFE_0001, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_outs", {resp_rdata[30:0], resp_valid} | 32'(resp_err), 32'd0);
    end
    rst = 1'b0;
    do_req(0, 3'b010, 32'h8, 32'h0, rd, er);
    check("rst_no_commit", rd, 32'hCAFE_0001);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [31:0] a;
      if (r == 0) a = $urandom;
      else if (r == 1) a = (DEPTH - 1) * 4 + $urandom_range(0, 3);
      else a = $urandom_range(0, 63);
      do_req(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
